// File: rtl/layer_compositor.sv
// rtl/layer_compositor.sv - N-layer priority pixel compositor with collision report and flash
module layer_compositor #(
    parameter int LAYERS       = 4,
    parameter int CH_W         = 4,
    parameter int FLASH_FRAMES = 8,
    localparam int RGB_W       = 3 * CH_W,
    localparam int PAIRS       = LAYERS * (LAYERS - 1) / 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [LAYERS*RGB_W-1:0] layer_rgb_i,
    input  logic [LAYERS-1:0]       layer_alpha_i,
    input  logic                    disp_i,
    input  logic                    frame_start_i,
    input  logic [LAYERS-1:0]       layer_en_i,
    input  logic                    dim_i,
    input  logic [RGB_W-1:0]        bg_rgb_i,
    input  logic [RGB_W-1:0]        flash_rgb_i,
    input  logic                    flash_req_i,
    output logic [RGB_W-1:0]        rgb_o,
    output logic                    disp_o,
    output logic [PAIRS-1:0]        coll_o,
    output logic                    coll_valid_o,
    output logic                    flash_active_o
);

    logic [LAYERS-1:0]       en_sh;
    logic                    dim_sh;

    logic [LAYERS-1:0]       alpha_s1;
    logic [LAYERS*RGB_W-1:0] rgb_s1;
    logic                    disp_s1;
    logic                    dim_s1;

    logic [7:0]              flash_cnt;
    logic [7:0]              flash_cnt_nxt;

    logic [PAIRS-1:0]        coll_acc;
    logic [PAIRS-1:0]        coll_now;

    logic                    hit;
    logic [RGB_W-1:0]        layer_px;
    logic [RGB_W-1:0]        pix;
    logic [RGB_W-1:0]        pix_out;

    // Per-frame shadow of enable mask and dim; pixels on the load edge still see old values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_sh  <= '1;
            dim_sh <= 1'b0;
        end else if (frame_start_i) begin
            en_sh  <= layer_en_i;
            dim_sh <= dim_i;
        end
    end

    // Stage 1: capture masked alphas, colours, visibility and the dim mode in force for this pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alpha_s1 <= '0;
            rgb_s1   <= '0;
            disp_s1  <= 1'b0;
            dim_s1   <= 1'b0;
        end else begin
            alpha_s1 <= layer_alpha_i & en_sh;
            rgb_s1   <= layer_rgb_i;
            disp_s1  <= disp_i;
            dim_s1   <= dim_sh;
        end
    end

    // Pair bit K enumerates (0,1),(0,2)..(0,N-1),(1,2)..(N-2,N-1)
    for (genvar i = 0; i < LAYERS - 1; i++) begin : g_row
        for (genvar j = i + 1; j < LAYERS; j++) begin : g_col
            localparam int K = i * (2 * LAYERS - i - 1) / 2 + (j - i - 1);
            assign coll_now[K] = disp_s1 & alpha_s1[i] & alpha_s1[j];
        end
    end

    // Lowest-index opaque layer wins; otherwise background (flash colour on odd counts)
    always_comb begin
        hit      = 1'b0;
        layer_px = '0;
        for (int k = LAYERS - 1; k >= 0; k--) begin
            if (alpha_s1[k]) begin
                hit      = 1'b1;
                layer_px = rgb_s1[k*RGB_W +: RGB_W];
            end
        end
        if (!disp_s1) begin
            pix = '0;
        end else if (hit) begin
            pix = layer_px;
        end else if (flash_cnt[0]) begin
            pix = flash_rgb_i;
        end else begin
            pix = bg_rgb_i;
        end
        pix_out = pix;
        if (dim_s1) begin
            for (int c = 0; c < 3; c++) begin
                pix_out[c*CH_W +: CH_W] = pix[c*CH_W +: CH_W] >> 1;
            end
        end
    end

    // Stage 2: registered pixel and aligned display enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_o  <= '0;
            disp_o <= 1'b0;
        end else begin
            rgb_o  <= pix_out;
            disp_o <= disp_s1;
        end
    end

    // Collision accumulation; frame start snapshots including this cycle's contribution
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_acc     <= '0;
            coll_o       <= '0;
            coll_valid_o <= 1'b0;
        end else begin
            coll_valid_o <= frame_start_i;
            if (frame_start_i) begin
                coll_o   <= coll_acc | coll_now;
                coll_acc <= '0;
            end else begin
                coll_acc <= coll_acc | coll_now;
            end
        end
    end

    // Flash counter: a request (re)loads and beats a coincident frame-start decrement
    always_comb begin
        flash_cnt_nxt = flash_cnt;
        if (flash_req_i) begin
            flash_cnt_nxt = 8'(FLASH_FRAMES);
        end else if (frame_start_i && (flash_cnt != 8'd0)) begin
            flash_cnt_nxt = flash_cnt - 8'd1;
        end
    end

    // Flash counter register and its registered activity flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flash_cnt      <= 8'd0;
            flash_active_o <= 1'b0;
        end else begin
            flash_cnt      <= flash_cnt_nxt;
            flash_active_o <= (flash_cnt_nxt != 8'd0);
        end
    end

endmodule

// File: tb/tb_layer_compositor.sv
// tb/tb_layer_compositor.sv - directed self-checking bench for layer_compositor
module tb_layer_compositor;

    localparam int LAYERS = 4;
    localparam int CH_W   = 4;
    localparam int RGB_W  = 12;
    localparam int PAIRS  = 6;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [LAYERS*RGB_W-1:0] layer_rgb_i;
    logic [LAYERS-1:0]       layer_alpha_i;
    logic                    disp_i;
    logic                    frame_start_i;
    logic [LAYERS-1:0]       layer_en_i;
    logic                    dim_i;
    logic [RGB_W-1:0]        bg_rgb_i;
    logic [RGB_W-1:0]        flash_rgb_i;
    logic                    flash_req_i;
    logic [RGB_W-1:0]        rgb_o;
    logic                    disp_o;
    logic [PAIRS-1:0]        coll_o;
    logic                    coll_valid_o;
    logic                    flash_active_o;

    int checks   = 0;
    int failures = 0;

    localparam logic [47:0] COLS     = {12'hFFF, 12'h00F, 12'h0F0, 12'hF00};
    localparam logic [47:0] COLS_DIM = {12'hFFF, 12'h00F, 12'h0F0, 12'hF84};

    layer_compositor #(.LAYERS(LAYERS), .CH_W(CH_W), .FLASH_FRAMES(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .layer_rgb_i    (layer_rgb_i),
        .layer_alpha_i  (layer_alpha_i),
        .disp_i         (disp_i),
        .frame_start_i  (frame_start_i),
        .layer_en_i     (layer_en_i),
        .dim_i          (dim_i),
        .bg_rgb_i       (bg_rgb_i),
        .flash_rgb_i    (flash_rgb_i),
        .flash_req_i    (flash_req_i),
        .rgb_o          (rgb_o),
        .disp_o         (disp_o),
        .coll_o         (coll_o),
        .coll_valid_o   (coll_valid_o),
        .flash_active_o (flash_active_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick2();
        tick();
        tick();
    endtask

    task automatic frame_pulse();
        frame_start_i = 1'b1;
        tick();
        frame_start_i = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        layer_rgb_i   = COLS;
        layer_alpha_i = '0;
        disp_i        = 1'b0;
        frame_start_i = 1'b0;
        layer_en_i    = 4'hF;
        dim_i         = 1'b0;
        bg_rgb_i      = 12'h123;
        flash_rgb_i   = 12'hABC;
        flash_req_i   = 1'b0;
        tick2();
        check("reset_rgb", 32'(rgb_o), 32'h0);
        check("reset_disp", 32'(disp_o), 32'h0);
        check("reset_coll", 32'(coll_o), 32'h0);
        check("reset_valid", 32'(coll_valid_o), 32'h0);
        check("reset_flash", 32'(flash_active_o), 32'h0);
        rst_n = 1'b1;
        tick();

        // priority
        disp_i = 1'b1; layer_alpha_i = 4'hF; tick2();
        check("prio_all", 32'(rgb_o), 32'hF00);
        check("prio_disp", 32'(disp_o), 32'h1);
        layer_alpha_i = 4'hE; tick2();
        check("prio_drop0", 32'(rgb_o), 32'h0F0);
        layer_alpha_i = 4'h0; tick2();
        check("prio_bg", 32'(rgb_o), 32'h123);

        // blanking
        disp_i = 1'b0; layer_alpha_i = 4'hF; tick2();
        check("blank_rgb", 32'(rgb_o), 32'h0);
        check("blank_disp", 32'(disp_o), 32'h0);

        // dim; this frame_start also reports the priority-test overlaps
        dim_i = 1'b1; frame_pulse(); dim_i = 1'b0;
        check("snap1_valid", 32'(coll_valid_o), 32'h1);
        check("snap1_coll", 32'(coll_o), 32'h3F);
        layer_rgb_i = COLS_DIM; layer_alpha_i = 4'b0001; disp_i = 1'b1; tick();
        check("snap1_pulse_len", 32'(coll_valid_o), 32'h0);
        tick();
        check("dim_pixel", 32'(rgb_o), 32'h742);
        disp_i = 1'b0; layer_alpha_i = 4'h0; layer_rgb_i = COLS; tick2();
        frame_pulse();
        check("snap2_valid", 32'(coll_valid_o), 32'h1);
        check("snap2_coll", 32'(coll_o), 32'h0);
        disp_i = 1'b1; layer_alpha_i = 4'h1; tick2();
        check("undim_pixel", 32'(rgb_o), 32'hF00);

        // collision (0,2)
        layer_alpha_i = 4'b0101; tick();
        layer_alpha_i = 4'b0000; tick2();
        frame_pulse();
        check("coll02", 32'(coll_o), 32'h2);
        check("coll02_valid", 32'(coll_valid_o), 32'h1);
        tick();
        check("coll02_valid_end", 32'(coll_valid_o), 32'h0);
        check("coll02_hold", 32'(coll_o), 32'h2);
        frame_pulse();
        check("coll_clear", 32'(coll_o), 32'h0);

        // enable mask
        layer_en_i = 4'b1110; frame_pulse();
        layer_alpha_i = 4'b0011; tick2();
        check("mask_l1", 32'(rgb_o), 32'h0F0);
        layer_en_i = 4'b1111; tick2();
        check("mask_midframe", 32'(rgb_o), 32'h0F0);
        layer_alpha_i = 4'h0; tick2();
        frame_pulse();
        check("mask_nocoll", 32'(coll_o), 32'h0);
        layer_alpha_i = 4'b0011; tick2();
        check("mask_applied", 32'(rgb_o), 32'hF00);
        layer_alpha_i = 4'h0; tick2();
        frame_pulse();
        check("mask_coll01", 32'(coll_o), 32'h1);

        // flash sequence
        flash_req_i = 1'b1; tick(); flash_req_i = 1'b0;
        check("flash_act_start", 32'(flash_active_o), 32'h1);
        tick();
        check("flash_cnt8_bg", 32'(rgb_o), 32'h123);
        for (int f = 1; f <= 8; f++) begin
            frame_pulse();
            tick();
            check($sformatf("flash_rgb_f%0d", f), 32'(rgb_o),
                  ((8 - f) % 2 == 1) ? 32'hABC : 32'h123);
            check($sformatf("flash_act_f%0d", f), 32'(flash_active_o),
                  (f < 8) ? 32'h1 : 32'h0);
        end
        flash_req_i = 1'b1; frame_start_i = 1'b1; tick();
        flash_req_i = 1'b0; frame_start_i = 1'b0;
        check("reload_act", 32'(flash_active_o), 32'h1);
        tick();
        check("reload_cnt8_bg", 32'(rgb_o), 32'h123);
        frame_pulse(); tick();
        check("reload_cnt7_flash", 32'(rgb_o), 32'hABC);

        // asynchronous reset mid-frame
        layer_alpha_i = 4'b0101; tick2(); tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_rgb", 32'(rgb_o), 32'h0);
        check("arst_disp", 32'(disp_o), 32'h0);
        check("arst_coll", 32'(coll_o), 32'h0);
        check("arst_flash", 32'(flash_active_o), 32'h0);
        layer_alpha_i = 4'h0; disp_i = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_rgb", 32'(rgb_o), 32'h0);
        tick();
        frame_pulse();
        check("post_rst_coll", 32'(coll_o), 32'h0);
        check("post_rst_valid", 32'(coll_valid_o), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/layer_compositor.md
# layer_compositor

Parametrised N-layer pixel compositor between the sprite generators and the VGA pins. It replaces a fixed four-layer priority mux with a configurable number of layers and a two-stage registered pipeline. It also adds per-frame layer-enable and dim shadow registers, a frame-counted background flash effect, and a per-frame pairwise collision report that game logic reads once per frame.

## Interface
- LAYERS, default 4: number of sprite layers; layer 0 has the highest priority (≥2).
- CH_W, default 4: bits per colour channel; RGB_W = 3*CH_W, packed {R,G,B}.
- FLASH_FRAMES, default 8: frames a flash lasts (1..255).
- PAIRS (localparam) = LAYERS*(LAYERS-1)/2.

- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous reset, active low.
- layer_rgb_i  in  LAYERS*RGB_W  layer k colour in bits [k*RGB_W +: RGB_W].
- layer_alpha_i  in  LAYERS  layer k pixel opaque.
- disp_i  in  1  current pixel is in the visible area.
- frame_start_i  in  1  one-cycle pulse, during blanking, once per frame.
- layer_en_i  in  LAYERS  layer enable mask, shadowed at frame_start_i.
- dim_i  in  1  half-intensity mode, shadowed at frame_start_i.
- bg_rgb_i  in  RGB_W  background colour.
- flash_rgb_i  in  RGB_W  background colour during flash-on frames.
- flash_req_i  in  1  pulse: (re)start flash.
- rgb_o  out  RGB_W  composited pixel.
- disp_o  out  1  disp_i delayed to align with rgb_o.
- coll_o  out  PAIRS  collision bits of the last completed frame.
- coll_valid_o  out  1  one-cycle pulse when coll_o updates.
- flash_active_o  out  1  flash counter nonzero.

## Operation
- **Shadow regs.** en_sh and dim_sh load from layer_en_i and dim_i on the edge where frame_start_i=1. Pixels sampled on that same edge still use the old values. Reset values: en_sh all ones, dim_sh 0.
- **Stage 1 (edge 1).** Registers the masked alpha (layer_alpha_i & en_sh), the layer colours, and disp_i.
- **Stage 2 (edge 2).** Output selection:
  - Visible and any masked alpha set: rgb = colour of the lowest-index set layer.
  - Visible and no alpha set: rgb = flash_rgb_i when flash_cnt≠0 and flash_cnt[0]=1, otherwise bg_rgb_i.
  - Not visible: rgb_o = 0.
- **Dim.** When dim_sh=1, every channel of a visible pixel is shifted right by 1. Blanking stays 0.
- **Collision pair ordering.** Pair bit index k enumerates (0,1),(0,2)…(0,N-1),(1,2)…(N-2,N-1).
- **Collision accumulation.** coll_acc[k] |= alpha_i & alpha_j whenever the stage-1 disp is 1. Masked alphas are used, so disabled layers never collide.
- **Collision snapshot.** On the edge where frame_start_i=1:
  - coll_o <= coll_acc | this-cycle contribution.
  - coll_acc <= 0.
  - coll_valid_o = 1 for exactly one cycle.
- **Flash counter.** flash_cnt is 8 bits.
  - flash_req_i loads FLASH_FRAMES.
  - Otherwise frame_start_i decrements it when nonzero.
  - flash_req_i and frame_start_i on the same edge: reload wins.
  - A req while the counter is running restarts it.
  - flash_active_o = (flash_cnt≠0), registered.

## Timing
- **Latency.** Fixed 2 cycles: inputs sampled at edge n appear on rgb_o/disp_o after edge n+1. There is no stall or backpressure.
- **Reset.** rgb_o=0, disp_o=0, coll_o=0, coll_valid_o=0, flash_active_o=0, flash_cnt=0, coll_acc=0, pipeline regs 0. Reset takes effect asynchronously, mid-line included; the first output after release is 0/blank until the pipeline refills.
- **Snapshot content.** coll_o holds its value between snapshots. A frame with no collisions snapshots to all zeros and still pulses coll_valid_o.
- **Enable-mask timing.** A layer_en_i change takes effect from the first pixel sampled after the frame_start edge, never mid-frame.
- **Flash toggling.** Flash-on frames are those with odd flash_cnt. With FLASH_FRAMES=8 the background shows flash_rgb_i for 4 of the 8 frames, starting from the second frame after the request.

## Test plan
- **Priority.** LAYERS=4, all alphas 1, layer colours 0xF00, 0x0F0, 0x00F, 0xFFF, disp=1 → rgb_o=0xF00 two cycles later. Drop alpha0 → 0x0F0. All alphas 0 → bg_rgb_i=0x123.
- **Blank and dim.** disp_i=0 with alphas set → rgb_o=0, disp_o=0. dim_i=1 plus frame_start, then pixel 0xF84 → 0x742.
- **Collision.** Alpha0 and alpha2 both set for one visible pixel, then frame_start → coll_o=6'b000010 (pair (0,2)), coll_valid_o pulse of 1 cycle. Next frame with no overlap → coll_o=0.
- **Mask.** layer_en_i=4'b1110 at frame_start; alpha0=alpha1=1 → rgb_o=layer1 colour, pair (0,1) bit stays 0. A mask change mid-frame has no effect until the next frame_start.
- **Flash.** flash_req_i, then 8 frame_starts → flash_cnt steps 8→0, background is flash_rgb_i only on the odd-count frames, flash_active_o falls after the 8th. A req coinciding with frame_start reloads to 8.
- **Reset.** Assert rst_n low mid-frame with flash active and coll_acc nonzero → all outputs 0 immediately. After release, the next frame_start gives coll_o=0.
